purse_deploy_ctrl: RTL
======================

Name: purse_deploy_ctrl

Overview:
Sequential economy controller for the battle field: accumulates money on game ticks, arbitrates unit-deploy and purse-upgrade requests, and keeps per-unit deploy cooldowns. It replaces the purse/cost tables used as bare lookups with a single stateful block. Its inputs come from the input/UI controller, and its outputs feed the army spawner and the HUD renderer.

Parameters:
MONEY_W, 15, money/cost datapath width
N_UNITS, 8, number of deployable army types (cooldown channels)
LVL_W, 3, purse level width; max level = 2**LVL_W-1
CD_W, 8, cooldown counter width (ticks)
INCOME_BASE, 5, money added per tick at level 0
INCOME_STEP, 3, extra money per tick per purse level

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick  in  1  single-cycle game-tick strobe
start  in  1  begin/resume the game
pause  in  1  pause the game
clear  in  1  synchronous return to IDLE (new game)
deploy_req  in  1  single-cycle deploy request
deploy_unit  in  $clog2(N_UNITS)  unit index
deploy_ack  out  1  one-cycle pulse: deploy granted
deploy_nack  out  1  one-cycle pulse: deploy refused
upgrade_req  in  1  single-cycle purse-upgrade request
upgrade_ack  out  1  one-cycle pulse: upgrade granted
upgrade_nack  out  1  one-cycle pulse: upgrade refused
money  out  MONEY_W  current money
level  out  LVL_W  current purse level
max_money  out  MONEY_W  cap for current level
upgrade_cost  out  MONEY_W  cost to upgrade from current level
cd_busy  out  N_UNITS  bit i = unit i cooling down
running  out  1  state == RUN

Behaviour:
- Reset values: money=0, level=0, all cooldowns=0, every ack/nack=0, state=IDLE.
- FSM IDLE -> RUN on start. RUN -> PAUSE on pause. PAUSE -> RUN on start. Any state -> IDLE on clear; clear beats start and pause. On entering IDLE, money, level and cooldowns are reset to their reset values.
- Requests received outside RUN produce nack the next cycle, with no state change. Ticks outside RUN are ignored.
- Latency: a request sampled at edge N produces its ack/nack pulse, and the money/level/cooldown update, visible after edge N+1.
- Deploy grant requires all of:
  - state RUN
  - cd[unit]==0
  - money >= unit_cost(unit)
- On deploy grant: money -= cost; cd[unit] = unit_cd(unit).
- Upgrade grant requires all of:
  - state RUN
  - level < max level
  - money after any same-cycle deploy >= upgrade cost(level)
- On upgrade grant: subtract the cost; level++.
- Same-cycle ordering, evaluated from registered values:
  1. deploy is checked first.
  2. upgrade is then checked against the post-deploy money.
  3. tick income (INCOME_BASE + level_new*INCOME_STEP) is added.
  4. the result saturates at max_money(level_new).
- Arithmetic: money never underflows, because the grant checks guarantee this. Addition uses MONEY_W+1 bits before saturation.
- At level max (7), max_money is 9999 and upgrade_cost is shown as all-ones. upgrade_req always nacks at max level.
- Cooldown on tick: each nonzero cd decrements by 1. A reload in the same cycle wins over the decrement. cd_busy[i] = (cd[i]!=0).
- deploy_unit >= N_UNITS: nack.
- Async reset mid-operation clears everything immediately, and no ack is emitted afterwards.

Optional Feature:
PURSE_COOLDOWN_EN
- Defined: per-unit cooldown counters are instantiated and behave as described above.
- Undefined: no counters; cd_busy is tied to 0 and deploy is gated only by money and state.

Decomposition:
- Package purse_pkg holds:
  - the FSM state enum (IDLE, RUN, PAUSE)
  - functions unit_cost(idx): 75, 150, 240, 350, 750, 1500, 2000, 2400
  - purse_max(lvl): 150, 300, 500, 1000, 2000, 4000, 6000, 9999
  - purse_up_cost(lvl): 100, 200, 400, 800, 1400, 3000, 5000
  - unit_cd(idx) in ticks: 20, 30, 40, 60, 100, 150, 200, 250
- Sub-module unit_cooldown (one per unit, generate loop): load, value, tick inputs; busy output.

Test Plan:
- Reset, start, 40 ticks at level 0 -> money climbs by 5 per tick, saturates at 150 after tick 30, running=1.
- Money 150, deploy unit0 -> deploy_ack one cycle later, money 75, cd_busy[0]=1. Repeat deploy unit0 -> deploy_nack, money stays 75. After 20 ticks cd_busy[0]=0.
- Money 75, upgrade_req -> upgrade_nack. Tick to 150, upgrade_req -> upgrade_ack, level 1, money 50, max_money 300, next tick adds 8.
- Money 150, deploy unit0 and upgrade_req in the same cycle together with a tick -> deploy_ack, upgrade_nack (75 < 100), money 80.
- Pause, then deploy and tick -> deploy_nack, money unchanged. Start -> income resumes. Clear -> money 0, level 0, cd_busy 0, state IDLE.
- Drive level to 7 and money to 9999 -> upgrade_req nacks, further ticks hold 9999. With the macro undefined, back-to-back deploys of unit0 both ack if money allows.

Source files
------------

// File: rtl/purse_pkg.sv
// Shared types and cost/limit tables for the battle-field economy controller.
// Pure combinational lookups; no latency.
// No flow control; callers index the tables directly.
package purse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // Money needed to deploy each army type.
  function automatic logic [15:0] unit_cost(input int idx);
    case (idx)
      0:       unit_cost = 16'd75;
      1:       unit_cost = 16'd150;
      2:       unit_cost = 16'd240;
      3:       unit_cost = 16'd350;
      4:       unit_cost = 16'd750;
      5:       unit_cost = 16'd1500;
      6:       unit_cost = 16'd2000;
      7:       unit_cost = 16'd2400;
      default: unit_cost = 16'hFFFF;
    endcase
  endfunction

  // Purse capacity at each level.
  function automatic logic [15:0] purse_max(input int lvl);
    case (lvl)
      0:       purse_max = 16'd150;
      1:       purse_max = 16'd300;
      2:       purse_max = 16'd500;
      3:       purse_max = 16'd1000;
      4:       purse_max = 16'd2000;
      5:       purse_max = 16'd4000;
      6:       purse_max = 16'd6000;
      default: purse_max = 16'd9999;
    endcase
  endfunction

  // Cost of moving from level lvl to lvl+1; all-ones once no upgrade exists.
  function automatic logic [15:0] purse_up_cost(input int lvl);
    case (lvl)
      0:       purse_up_cost = 16'd100;
      1:       purse_up_cost = 16'd200;
      2:       purse_up_cost = 16'd400;
      3:       purse_up_cost = 16'd800;
      4:       purse_up_cost = 16'd1400;
      5:       purse_up_cost = 16'd3000;
      6:       purse_up_cost = 16'd5000;
      default: purse_up_cost = 16'hFFFF;
    endcase
  endfunction

  // Ticks a unit type stays unavailable after a deploy.
  function automatic logic [15:0] unit_cd(input int idx);
    case (idx)
      0:       unit_cd = 16'd20;
      1:       unit_cd = 16'd30;
      2:       unit_cd = 16'd40;
      3:       unit_cd = 16'd60;
      4:       unit_cd = 16'd100;
      5:       unit_cd = 16'd150;
      6:       unit_cd = 16'd200;
      default: unit_cd = 16'd250;
    endcase
  endfunction

endpackage

// File: rtl/unit_cooldown.sv
// Per-unit deploy cooldown counter: reloads on grant, counts down on game ticks.
// busy is registered; a load becomes visible one cycle after it is applied.
// No flow control; load beats the tick decrement, clr beats both.
module unit_cooldown #(
  parameter int CD_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            load,
  input  logic [CD_W-1:0] value,
  input  logic            tick,
  output logic            busy
);

  logic [CD_W-1:0] cnt;

  // Counter: new game clears, a grant reloads, a tick drains toward zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/purse_deploy_ctrl.sv
// Economy controller: tick income, deploy/upgrade arbitration, per-unit cooldowns (PURSE_COOLDOWN_EN).
// Requests are captured at one edge and answered, with money/level updated, at the next edge.
// No backpressure; every request gets exactly one ack or nack pulse, nack outside RUN.
module purse_deploy_ctrl
  import purse_pkg::*;
#(
  parameter int MONEY_W     = 15,
  parameter int N_UNITS     = 8,
  parameter int LVL_W       = 3,
  parameter int CD_W        = 8,
  parameter int INCOME_BASE = 5,
  parameter int INCOME_STEP = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tick,
  input  logic                       start,
  input  logic                       pause,
  input  logic                       clear,
  input  logic                       deploy_req,
  input  logic [$clog2(N_UNITS)-1:0] deploy_unit,
  output logic                       deploy_ack,
  output logic                       deploy_nack,
  input  logic                       upgrade_req,
  output logic                       upgrade_ack,
  output logic                       upgrade_nack,
  output logic [MONEY_W-1:0]         money,
  output logic [LVL_W-1:0]           level,
  output logic [MONEY_W-1:0]         max_money,
  output logic [MONEY_W-1:0]         upgrade_cost,
  output logic [N_UNITS-1:0]         cd_busy,
  output logic                       running
);

  localparam int UNIT_W = $clog2(N_UNITS);
  localparam logic [LVL_W-1:0] LVL_MAX = '1;

  state_t              state;
  logic                tick_q;
  logic                dep_q;
  logic                up_q;
  logic [UNIT_W-1:0]   unit_q;
  logic [N_UNITS-1:0]  cd_busy_w;

  logic                is_run;
  logic                unit_ok;
  logic [MONEY_W-1:0]  dep_cost;
  logic                dep_grant;
  logic [MONEY_W-1:0]  money_a;
  logic [MONEY_W-1:0]  up_cost;
  logic                up_grant;
  logic [MONEY_W-1:0]  money_b;
  logic [LVL_W-1:0]    level_n;
  logic [MONEY_W:0]    income;
  logic [MONEY_W:0]    sum;
  logic [MONEY_W:0]    cap;
  logic [MONEY_W-1:0]  money_n;

  // Request capture stage; reset drops anything in flight so nothing is answered afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= 1'b0;
      dep_q  <= 1'b0;
      up_q   <= 1'b0;
      unit_q <= '0;
    end else begin
      tick_q <= tick;
      dep_q  <= deploy_req;
      up_q   <= upgrade_req;
      unit_q <= deploy_unit;
    end
  end

  // A clear in the answering cycle wins: the game is being torn down, so refuse.
  assign is_run   = (state == RUN) && !clear;
  assign unit_ok  = (int'(unit_q) < N_UNITS);

  // Deploy first, from registered money and cooldown.
  assign dep_cost  = MONEY_W'(unit_cost(int'(unit_q)));
  assign dep_grant = dep_q && is_run && unit_ok && !cd_busy_w[unit_q] && (money_r_ge_cost());
  assign money_a   = dep_grant ? (money - dep_cost) : money;

  // Upgrade sees what is left after the deploy.
  assign up_cost  = MONEY_W'(purse_up_cost(int'(level)));
  assign up_grant = up_q && is_run && (level != LVL_MAX) && (money_a >= up_cost);
  assign money_b  = up_grant ? (money_a - up_cost) : money_a;
  assign level_n  = up_grant ? (level + 1'b1) : level;

  // Income uses the post-upgrade level, then clamp to that level's purse.
  assign income  = (tick_q && is_run) ?
                   (MONEY_W+1)'(INCOME_BASE + INCOME_STEP * int'(level_n)) : '0;
  assign sum     = {1'b0, money_b} + income;
  assign cap     = (MONEY_W+1)'(purse_max(int'(level_n)));
  assign money_n = (sum > cap) ? cap[MONEY_W-1:0] : sum[MONEY_W-1:0];

  function automatic logic money_r_ge_cost();
    return (money >= dep_cost);
  endfunction

  // Game state, purse and one-cycle response pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      money        <= '0;
      level        <= '0;
      deploy_ack   <= 1'b0;
      deploy_nack  <= 1'b0;
      upgrade_ack  <= 1'b0;
      upgrade_nack <= 1'b0;
    end else begin
      deploy_ack   <= dep_grant;
      deploy_nack  <= dep_q && !dep_grant;
      upgrade_ack  <= up_grant;
      upgrade_nack <= up_q && !up_grant;
      if (clear) begin
        state <= IDLE;
        money <= '0;
        level <= '0;
      end else begin
        money <= money_n;
        level <= level_n;
        case (state)
          IDLE:    if (start) state <= RUN;
          RUN:     if (pause) state <= PAUSE;
          PAUSE:   if (start) state <= RUN;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef PURSE_COOLDOWN_EN
  // One countdown per unit type; ticks only count while the game runs.
  for (genvar i = 0; i < N_UNITS; i++) begin : g_cd
    unit_cooldown #(.CD_W(CD_W)) u_cd (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clear),
      .load  (dep_grant && (unit_q == UNIT_W'(i))),
      .value (CD_W'(unit_cd(i))),
      .tick  (tick_q && is_run),
      .busy  (cd_busy_w[i])
    );
  end
`else
  // Without cooldowns a unit is always available; deploys are gated by money and state.
  logic [CD_W-1:0] unused_cd_w;
  assign unused_cd_w = CD_W'(unit_cd(int'(unit_q)));
  assign cd_busy_w   = '0;
`endif

  assign cd_busy      = cd_busy_w;
  assign running      = (state == RUN);
  assign max_money    = MONEY_W'(purse_max(int'(level)));
  assign upgrade_cost = up_cost;

endmodule
